fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch front end that replaces the single-register PC / IF_ID path with a decoupled prefetch queue.
- Issues sequential fetch requests to an instruction memory with variable latency, keeping up to MAX_OUTSTANDING requests in flight.
- Buffers returned instructions with their PCs in a QUEUE_DEPTH FIFO and presents them to decode with a valid/stall handshake.
- Handles branch redirects from EX by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_queue_unit.sv | 137 +++++++++++++
 tb/tb_fetch_queue_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: decoupled instruction prefetch front end.
// Issues sequential word fetches to a variable-latency instruction memory,
// buffers returned words with their PCs in a small FIFO and hands them to
// decode through a valid/stall handshake. Branch redirects flush the FIFO
// and discard responses still in flight for the old stream.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   redirect, redirectTarget   taken branch from EX and its target PC
//   decodeStall                decode cannot accept the head entry
//   imemRequest, imemAddress   fetch request and word-aligned address
//   imemReady                  memory accepts the request this cycle
//   imemResponseValid/Data     in-order returned instruction word
//   idValid, idInstruction,
//   idProgramCounter           head-of-queue entry presented to decode
//   queueCount                 occupied queue entries
module fetch_queue_unit #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     QUEUE_DEPTH     = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             redirect,
    input  logic [XLEN-1:0]                  redirectTarget,
    input  logic                             decodeStall,
    output logic                             imemRequest,
    output logic [XLEN-1:0]                  imemAddress,
    input  logic                             imemReady,
    input  logic                             imemResponseValid,
    input  logic [31:0]                      imemResponseData,
    output logic                             idValid,
    output logic [31:0]                      idInstruction,
    output logic [XLEN-1:0]                  idProgramCounter,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queueCount
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]  fetchPc;
    logic [XLEN-1:0]  responsePc;
    logic [31:0]      instrMem [QUEUE_DEPTH];
    logic [XLEN-1:0]  pcMem    [QUEUE_DEPTH];
    logic [PTR_W-1:0] readPtr;
    logic [PTR_W-1:0] writePtr;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] discard;

    logic             accept;
    logic             pushEn;
    logic             popEn;
    logic             dropEn;
    logic [OUT_W-1:0] redirectDiscard;
    logic [XLEN-1:0]  alignedTarget;
    logic             unusedTargetBits;

    assign unusedTargetBits = ^redirectTarget[1:0];
    assign alignedTarget    = {redirectTarget[XLEN-1:2], 2'b00};

    // Issue/accept/push/pop decisions; queue slots are reserved at issue time
    always_comb begin
        imemRequest      = 1'b0;
        accept           = 1'b0;
        pushEn           = 1'b0;
        popEn            = 1'b0;
        dropEn           = 1'b0;
        redirectDiscard  = '0;

        idValid          = (count != '0);
        idInstruction    = instrMem[readPtr];
        idProgramCounter = pcMem[readPtr];
        queueCount       = count;
        imemAddress      = fetchPc;

        imemRequest = !reset && !redirect
                   && ((32'(count) + 32'(outstanding)) < QUEUE_DEPTH)
                   && ((32'(outstanding) + 32'(discard)) < MAX_OUTSTANDING);
        accept      = imemRequest && imemReady;
        dropEn      = imemResponseValid && (discard != '0);
        pushEn      = imemResponseValid && (discard == '0) && !redirect;
        popEn       = idValid && !decodeStall && !redirect;

        // Everything still in flight becomes stale; a response landing in the
        // redirect cycle is the oldest of those and retires one of them.
        if (imemResponseValid && ((32'(discard) + 32'(outstanding)) != 0)) begin
            redirectDiscard = OUT_W'(32'(discard) + 32'(outstanding) - 32'd1);
        end else begin
            redirectDiscard = OUT_W'(32'(discard) + 32'(outstanding));
        end
    end

    // Fetch PCs, counters and FIFO storage
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc     <= RESET_PC;
            responsePc  <= RESET_PC;
            readPtr     <= '0;
            writePtr    <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                instrMem[i] <= '0;
                pcMem[i]    <= '0;
            end
        end else if (redirect) begin
            fetchPc     <= alignedTarget;
            responsePc  <= alignedTarget;
            readPtr     <= '0;
            writePtr    <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= redirectDiscard;
        end else begin
            if (accept) begin
                fetchPc <= fetchPc + XLEN'(4);
            end
            if (pushEn) begin
                instrMem[writePtr] <= imemResponseData;
                pcMem[writePtr]    <= responsePc;
                writePtr           <= writePtr + PTR_W'(1);
                responsePc         <= responsePc + XLEN'(4);
            end
            if (popEn) begin
                readPtr <= readPtr + PTR_W'(1);
            end
            count       <= count + CNT_W'(pushEn) - CNT_W'(popEn);
            outstanding <= outstanding + OUT_W'(accept) - OUT_W'(pushEn);
            discard     <= discard - OUT_W'(dropEn);
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: directed vector table, hand-written corner
// sequences and randomized traffic against an epoch-tagged queue model.
module tb_fetch_queue_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
    localparam int unsigned NROWS = 28;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic        decodeStall;
    logic        imemRequest;
    logic [31:0] imemAddress;
    logic        imemReady;
    logic        imemResponseValid;
    logic [31:0] imemResponseData;
    logic        idValid;
    logic [31:0] idInstruction;
    logic [31:0] idProgramCounter;
    logic [2:0]  queueCount;

    fetch_queue_unit #(
        .XLEN(XLEN), .QUEUE_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC('0)
    ) dut (
        .clk(clk), .reset(reset), .redirect(redirect),
        .redirectTarget(redirectTarget), .decodeStall(decodeStall),
        .imemRequest(imemRequest), .imemAddress(imemAddress),
        .imemReady(imemReady), .imemResponseValid(imemResponseValid),
        .imemResponseData(imemResponseData), .idValid(idValid),
        .idInstruction(idInstruction), .idProgramCounter(idProgramCounter),
        .queueCount(queueCount)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight requests tagged with the fetch stream (epoch)
    // they belong to; responses of an older epoch are dropped.
    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        longint      readyCyc;
    } req_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    typedef struct {
        logic        r;
        logic        rd;
        logic [31:0] tgt;
        logic        st;
        logic        exReq;
        logic [31:0] exAddr;
        logic        exValid;
        logic [31:0] exPc;
        int unsigned exCnt;
    } vec_t;

    req_t        infl[$];
    ent_t        mq[$];
    logic [31:0] mFetch;
    int unsigned epoch;
    longint      cyc;
    longint      lastReady;
    int unsigned lat;
    logic        mInReset;
    logic        mReq;
    int unsigned vectors;
    int unsigned miscompares;
    vec_t        tbl[NROWS];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC001};
    endfunction

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] tgt,
                                input logic st, input logic exReq, input logic [31:0] exAddr,
                                input logic exValid, input logic [31:0] exPc,
                                input int unsigned exCnt);
        vec_t v;
        v.r = r; v.rd = rd; v.tgt = tgt; v.st = st; v.exReq = exReq; v.exAddr = exAddr;
        v.exValid = exValid; v.exPc = exPc; v.exCnt = exCnt;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply inputs for this cycle and compute the expected request from the model
    task automatic drive(input logic r, input logic rd, input logic [31:0] tgt,
                         input logic st, input logic rdy);
        int unsigned nCur;
        reset          = r;
        redirect       = rd;
        redirectTarget = tgt;
        decodeStall    = st;
        imemReady      = rdy;
        if (!r && infl.size() > 0 && infl[0].readyCyc <= cyc) begin
            imemResponseValid = 1'b1;
            imemResponseData  = memWord(infl[0].addr);
        end else begin
            imemResponseValid = 1'b0;
            imemResponseData  = $urandom;
        end
        nCur = 0;
        foreach (infl[i]) if (infl[i].epoch == epoch) nCur++;
        mReq = !r && !rd && (mq.size() + nCur < DEPTH) && (infl.size() < MAXO);
        #3;
    endtask

    task automatic check_model();
        cmp("imemRequest", 32'(imemRequest), 32'(mReq));
        cmp("imemAddress", imemAddress, mFetch);
        cmp("idValid", 32'(idValid), 32'(mq.size() != 0));
        cmp("queueCount", 32'(queueCount), 32'(mq.size()));
        if (mq.size() != 0) begin
            cmp("idProgramCounter", idProgramCounter, mq[0].pc);
            cmp("idInstruction", idInstruction, mq[0].instr);
        end else if (mInReset) begin
            cmp("idProgramCounter_reset", idProgramCounter, 32'h0);
            cmp("idInstruction_reset", idInstruction, 32'h0);
        end
    endtask

    // Update the model for the coming clock edge, then advance one cycle
    task automatic advance();
        req_t front;
        logic respTaken;
        ent_t e;
        if (reset) begin
            infl.delete();
            mq.delete();
            mFetch    = 32'h0;
            epoch     = epoch + 1;
            lastReady = 0;
            mInReset  = 1'b1;
        end else begin
            mInReset  = 1'b0;
            respTaken = imemResponseValid;
            if (respTaken) front = infl.pop_front();
            if (redirect) begin
                mq.delete();
                epoch  = epoch + 1;
                mFetch = {redirectTarget[31:2], 2'b00};
            end else begin
                if (mq.size() != 0 && !decodeStall) void'(mq.pop_front());
                if (respTaken && front.epoch == epoch) begin
                    e.instr = memWord(front.addr);
                    e.pc    = front.addr;
                    mq.push_back(e);
                end
                if (mReq && imemReady) begin
                    front.addr     = mFetch;
                    front.epoch    = epoch;
                    front.readyCyc = (cyc + longint'(lat) > lastReady) ? cyc + longint'(lat)
                                                                       : lastReady + 1;
                    lastReady      = front.readyCyc;
                    infl.push_back(front);
                    mFetch = mFetch + 32'd4;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] tgt,
                        input logic st, input logic rdy);
        drive(r, rd, tgt, st, rdy);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r32;
        logic        found;
        int unsigned seen;
        vectors = 0; miscompares = 0;
        epoch = 0; cyc = 0; lastReady = 0; lat = 1;
        mFetch = 32'h0; mInReset = 1'b1; mReq = 1'b0;

        // Startup, streaming, stall-to-full, release and redirect with 1-cycle memory
        for (int i = 0; i < 3; i++) tbl[i] = mk(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 32'h00, 0, 32'h00, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1, 32'h04, 0, 32'h00, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 32'h08, 1, 32'h00, 1);
        tbl[6]  = mk(0, 0, 0, 0, 1, 32'h0C, 1, 32'h04, 1);
        tbl[7]  = mk(0, 0, 0, 0, 1, 32'h10, 1, 32'h08, 1);
        tbl[8]  = mk(0, 0, 0, 0, 1, 32'h14, 1, 32'h0C, 1);
        tbl[9]  = mk(0, 0, 0, 1, 1, 32'h18, 1, 32'h10, 1);
        tbl[10] = mk(0, 0, 0, 1, 1, 32'h1C, 1, 32'h10, 2);
        tbl[11] = mk(0, 0, 0, 1, 0, 32'h20, 1, 32'h10, 3);
        for (int i = 12; i < 19; i++) tbl[i] = mk(0, 0, 0, 1, 0, 32'h20, 1, 32'h10, 4);
        tbl[19] = mk(0, 0, 0, 0, 0, 32'h20, 1, 32'h10, 4);
        tbl[20] = mk(0, 0, 0, 0, 1, 32'h20, 1, 32'h14, 3);
        tbl[21] = mk(0, 0, 0, 0, 1, 32'h24, 1, 32'h18, 2);
        tbl[22] = mk(0, 0, 0, 0, 1, 32'h28, 1, 32'h1C, 2);
        tbl[23] = mk(0, 0, 0, 0, 1, 32'h2C, 1, 32'h20, 2);
        tbl[24] = mk(0, 1, 32'h103, 0, 0, 32'h30, 1, 32'h24, 2);
        tbl[25] = mk(0, 0, 0, 0, 1, 32'h100, 0, 32'h0, 0);
        tbl[26] = mk(0, 0, 0, 0, 1, 32'h104, 0, 32'h0, 0);
        tbl[27] = mk(0, 0, 0, 0, 1, 32'h108, 1, 32'h100, 1);

        reset = 1'b1; redirect = 1'b0; redirectTarget = '0; decodeStall = 1'b0;
        imemReady = 1'b1; imemResponseValid = 1'b0; imemResponseData = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < int'(NROWS); i++) begin
            drive(tbl[i].r, tbl[i].rd, tbl[i].tgt, tbl[i].st, 1'b1);
            check_model();
            cmp($sformatf("row%0d_req", i), 32'(imemRequest), 32'(tbl[i].exReq));
            cmp($sformatf("row%0d_addr", i), imemAddress, tbl[i].exAddr);
            cmp($sformatf("row%0d_valid", i), 32'(idValid), 32'(tbl[i].exValid));
            cmp($sformatf("row%0d_count", i), 32'(queueCount), tbl[i].exCnt);
            if (tbl[i].exValid) begin
                cmp($sformatf("row%0d_pc", i), idProgramCounter, tbl[i].exPc);
                cmp($sformatf("row%0d_instr", i), idInstruction, memWord(tbl[i].exPc));
            end
            advance();
        end

        // Two stale responses in flight at a redirect, 3-cycle memory
        do_reset();
        lat = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h103, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check_model();
            if (idValid) begin
                found = 1'b1;
                cmp("redirect_first_pc", idProgramCounter, 32'h100);
                cmp("redirect_first_instr", idInstruction, memWord(32'h100));
            end
            advance();
        end
        if (!found) cmp("redirect_first_valid_timeout", 32'(found), 32'h1);

        // Memory back-pressure holds the request address
        do_reset();
        lat = 1;
        step(1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check_model();
            cmp("hold_addr", imemAddress, 32'h20);
            cmp("hold_req", 32'(imemRequest), 32'h1);
            advance();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_model();
        cmp("accept_addr", imemAddress, 32'h20);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_model();
        cmp("after_accept_addr", imemAddress, 32'h24);
        advance();

        // Fetch and response PC wrap at the top of the address space
        do_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_model();
        cmp("wrap_addr_top", imemAddress, 32'hFFFF_FFFC);
        advance();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_model();
        cmp("wrap_addr_zero", imemAddress, 32'h0);
        advance();
        seen = 0;
        for (int i = 0; i < 10 && seen < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check_model();
            if (idValid) begin
                cmp("wrap_pc", idProgramCounter, (seen == 0) ? 32'hFFFF_FFFC : 32'h0);
                seen++;
            end
            advance();
        end
        if (seen < 2) cmp("wrap_pc_timeout", seen, 32'd2);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            r32 = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            step(($urandom % 600) == 0, ($urandom % 25) == 0, r32,
                 ($urandom % 3) == 0, ($urandom % 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
